// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the memory bus arbiter.
//   ArbState : IDLE / ISSUE / WAIT transaction phases
//   ArbOwner : which requester owns the current bus transaction
//   BE_ALL   : byte enables used for instruction fetches
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } ArbState;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_I = 1'b1
  } ArbOwner;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/defines.sv
`default_nettype none
// ---------------------------------------------------------------------------
// defines.sv
// Core-wide bus width and constant macros shared across the pipeline.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`ifndef DEFINES_SV
`define DEFINES_SV
`define MemBus     31:0
`define MemAddrBus 31:0
`define ZeroWord   32'h00000000
`endif
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_pick
// Winner select between the data (D) and fetch (I) requesters plus the
// D-streak counter that keeps fetch from starving.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   d_req      : data port requesting this cycle
//   i_req      : fetch port requesting this cycle
//   gnt        : a grant is issued this cycle to 'owner'
//   owner      : combinational winner for the current requests
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    d_req,
  input  logic    i_req,
  input  logic    gnt,
  output ArbOwner owner
);

  localparam int             SW         = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_D_STREAK);

  // Number of consecutive D grants made while I was waiting.
  logic [SW-1:0] streak;

  always_comb begin
    owner = OWN_D;
    if (i_req && (!d_req || streak == STREAK_MAX)) begin
      owner = OWN_I;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (gnt) begin
      if (owner == OWN_D && i_req) begin
        if (streak != STREAK_MAX) begin
          streak <= streak + 1'b1;
        end
      end else begin
        streak <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`include "defines.sv"
`default_nettype none
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares the single memory bus between the MEM-stage data port (D) and the
// instruction-fetch port (I). One transaction in flight at a time; each one
// finishes with exactly one rvalid pulse to its owner, or an error
// completion if the bus does not answer within TIMEOUT_CYC cycles.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   d_req_i .. d_be_i    : data request and payload (held until d_gnt_o)
//   d_gnt_o              : data grant pulse (payload captured this cycle)
//   d_rvalid_o/rdata/err : data completion
//   i_req_i, i_addr_i    : fetch request (held until i_gnt_o)
//   i_gnt_o              : fetch grant pulse
//   i_rvalid_o/rdata/err : fetch completion
//   bus_*_o              : request towards memory, stable while bus_req_o
//   bus_gnt_i            : memory accepts the request
//   bus_rvalid_i/rdata_i : memory response
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [`MemAddrBus]  d_addr_i,
  input  logic [`MemBus]      d_wdata_i,
  input  logic [3:0]          d_be_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [`MemBus]      d_rdata_o,
  output logic                d_err_o,
  input  logic                i_req_i,
  input  logic [`MemAddrBus]  i_addr_i,
  output logic                i_gnt_o,
  output logic                i_rvalid_o,
  output logic [`MemBus]      i_rdata_o,
  output logic                i_err_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [`MemAddrBus]  bus_addr_o,
  output logic [`MemBus]      bus_wdata_o,
  output logic [3:0]          bus_be_o,
  input  logic                bus_gnt_i,
  input  logic                bus_rvalid_i,
  input  logic [`MemBus]      bus_rdata_i
);

  localparam int            TW         = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  ArbState       state;
  ArbState       state_nxt;
  ArbOwner       owner;
  ArbOwner       pick;
  logic [TW-1:0] timer;
  logic          grant;
  logic          rsp_ok;
  logic          rsp_tmo;

  mem_arb_pick #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_pick (
    .clk   (clk),
    .rst_n (rst_n),
    .d_req (d_req_i),
    .i_req (i_req_i),
    .gnt   (grant),
    .owner (pick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    rsp_ok    = 1'b0;
    rsp_tmo   = 1'b0;
    case (state)
      IDLE: begin
        if (d_req_i || i_req_i) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus_gnt_i) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A response arriving on the timeout cycle still counts as success.
        if (bus_rvalid_i) begin
          rsp_ok    = 1'b1;
          state_nxt = IDLE;
        end else if (timer == TIMER_LAST) begin
          rsp_tmo   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign d_gnt_o   = grant && (pick == OWN_D);
  assign i_gnt_o   = grant && (pick == OWN_I);
  // Decoded from the state register, so reset drops it on the next cycle.
  assign bus_req_o = (state == ISSUE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner       <= OWN_D;
      timer       <= '0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= `ZeroWord;
      bus_wdata_o <= `ZeroWord;
      bus_be_o    <= 4'h0;
      d_rvalid_o  <= 1'b0;
      d_rdata_o   <= `ZeroWord;
      d_err_o     <= 1'b0;
      i_rvalid_o  <= 1'b0;
      i_rdata_o   <= `ZeroWord;
      i_err_o     <= 1'b0;
    end else begin
      d_rvalid_o <= 1'b0;
      i_rvalid_o <= 1'b0;

      if (grant) begin
        owner <= pick;
        if (pick == OWN_I) begin
          bus_we_o    <= 1'b0;
          bus_addr_o  <= i_addr_i;
          bus_wdata_o <= `ZeroWord;
          bus_be_o    <= BE_ALL;
        end else begin
          bus_we_o    <= d_we_i;
          bus_addr_o  <= d_addr_i;
          bus_wdata_o <= d_wdata_i;
          bus_be_o    <= d_be_i;
        end
      end

      if (state == ISSUE && bus_gnt_i) begin
        timer <= '0;
      end else if (state == WAIT) begin
        timer <= timer + 1'b1;
      end

      if (rsp_ok || rsp_tmo) begin
        if (owner == OWN_D) begin
          d_rvalid_o <= 1'b1;
          d_rdata_o  <= rsp_ok ? bus_rdata_i : `ZeroWord;
          d_err_o    <= rsp_tmo;
        end else begin
          i_rvalid_o <= 1'b1;
          i_rdata_o  <= rsp_ok ? bus_rdata_i : `ZeroWord;
          i_err_o    <= rsp_tmo;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a
// randomized run scored against a transaction-level reference model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int MAX_D_STREAK = 4;
  localparam int TIMEOUT_CYC  = 8;

  logic        clk;
  logic        rst_n;
  logic        d_req_i, d_we_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic [3:0]  d_be_i;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o, i_rvalid_o, i_err_o;
  logic [31:0] i_rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  mem_bus_arbiter #(
    .MAX_D_STREAK (MAX_D_STREAK),
    .TIMEOUT_CYC  (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .d_req_i      (d_req_i),
    .d_we_i       (d_we_i),
    .d_addr_i     (d_addr_i),
    .d_wdata_i    (d_wdata_i),
    .d_be_i       (d_be_i),
    .d_gnt_o      (d_gnt_o),
    .d_rvalid_o   (d_rvalid_o),
    .d_rdata_o    (d_rdata_o),
    .d_err_o      (d_err_o),
    .i_req_i      (i_req_i),
    .i_addr_i     (i_addr_i),
    .i_gnt_o      (i_gnt_o),
    .i_rvalid_o   (i_rvalid_o),
    .i_rdata_o    (i_rdata_o),
    .i_err_o      (i_err_o),
    .bus_req_o    (bus_req_o),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_be_o     (bus_be_o),
    .bus_gnt_i    (bus_gnt_i),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: D grants in a row while fetch was waiting.
  int d_run = 0;

  // Observations recorded by run_one.
  logic        ob_d_gnt, ob_i_gnt, ob_rv_stale, ob_stable, ob_extra_gnt;
  logic        ob_busreq_after, ob_d_rv, ob_i_rv, ob_err, ob_we;
  logic [31:0] ob_addr, ob_wdata, ob_rdata;
  logic [3:0]  ob_be;
  int          ob_lat, ob_gnt_cyc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_pick(input bit dr, input bit ir, output bit to_i);
    to_i = ir && (!dr || d_run == MAX_D_STREAK);
    if (!to_i && ir) d_run = (d_run < MAX_D_STREAK) ? d_run + 1 : d_run;
    else             d_run = 0;
  endtask

  // Drives one transaction from the grant cycle to the completion pulse and
  // records what the DUT did. Returns in the pulse cycle, without stepping.
  task automatic run_one(input int gnt_delay, input int rsp_delay,
                         input logic [31:0] rsp_data, input bit keep);
    int lat;
    #1;
    ob_d_gnt = d_gnt_o;
    ob_i_gnt = i_gnt_o;
    ob_gnt_cyc = cyc;
    step();
    if (!keep) begin
      if (ob_d_gnt) d_req_i = 1'b0;
      if (ob_i_gnt) i_req_i = 1'b0;
    end
    ob_rv_stale  = d_rvalid_o | i_rvalid_o;
    ob_we        = bus_we_o;
    ob_addr      = bus_addr_o;
    ob_wdata     = bus_wdata_o;
    ob_be        = bus_be_o;
    ob_stable    = 1'b1;
    ob_extra_gnt = 1'b0;
    for (int g = 0; g <= gnt_delay; g++) begin
      if (bus_req_o !== 1'b1 || bus_we_o !== ob_we || bus_addr_o !== ob_addr ||
          bus_wdata_o !== ob_wdata || bus_be_o !== ob_be) ob_stable = 1'b0;
      bus_gnt_i = (g == gnt_delay);
      #1;
      if (d_gnt_o || i_gnt_o) ob_extra_gnt = 1'b1;
      step();
    end
    bus_gnt_i = 1'b0;
    ob_busreq_after = bus_req_o;
    ob_lat = -1;
    ob_d_rv = 1'b0;
    ob_i_rv = 1'b0;
    ob_rdata = 32'hx;
    ob_err = 1'bx;
    lat = 1;
    for (int k = 0; k < 40; k++) begin
      bus_rvalid_i = 1'b0;
      if (d_rvalid_o || i_rvalid_o) begin
        ob_lat   = lat;
        ob_d_rv  = d_rvalid_o;
        ob_i_rv  = i_rvalid_o;
        ob_rdata = d_rvalid_o ? d_rdata_o : i_rdata_o;
        ob_err   = d_rvalid_o ? d_err_o : i_err_o;
        break;
      end
      bus_rvalid_i = (k == rsp_delay);
      bus_rdata_i  = rsp_data;
      #1;
      if (d_gnt_o || i_gnt_o) ob_extra_gnt = 1'b1;
      step();
      lat++;
    end
    bus_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0; d_be_i = 0;
    i_req_i = 0; i_addr_i = 0;
    bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
    d_run = 0;
    repeat (3) step();
    checks++; if (bus_req_o !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bus_req_o); end
    checks++; if ({bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} !== 69'd0) begin errors++; $display("FAIL reset_bus_payload: got we=%b addr=%h wdata=%h be=%h want all 0", bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o); end
    checks++; if ({d_rvalid_o, d_err_o, d_rdata_o} !== 34'd0) begin errors++; $display("FAIL reset_d_out: got rv=%b err=%b rdata=%h want 0", d_rvalid_o, d_err_o, d_rdata_o); end
    checks++; if ({i_rvalid_o, i_err_o, i_rdata_o} !== 34'd0) begin errors++; $display("FAIL reset_i_out: got rv=%b err=%b rdata=%h want 0", i_rvalid_o, i_err_o, i_rdata_o); end
    checks++; if ({d_gnt_o, i_gnt_o} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b%b want 00", d_gnt_o, i_gnt_o); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_d_read();
    bit to_i;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h100; d_wdata_i = 32'h0; d_be_i = 4'hF;
    model_pick(1'b1, 1'b0, to_i);
    run_one(0, 1, 32'hDEADBEEF, 0);
    checks++; if ({ob_d_gnt, ob_i_gnt} !== 2'b10) begin errors++; $display("FAIL dread_gnt: got d=%b i=%b want d=1 i=0", ob_d_gnt, ob_i_gnt); end
    checks++; if (ob_addr !== 32'h100 || ob_we !== 1'b0 || ob_stable !== 1'b1) begin errors++; $display("FAIL dread_bus: got addr=%h we=%b stable=%b want addr=100 we=0 stable=1", ob_addr, ob_we, ob_stable); end
    checks++; if (ob_busreq_after !== 1'b0) begin errors++; $display("FAIL dread_req_drop: got %b want 0", ob_busreq_after); end
    checks++; if (ob_lat !== 3) begin errors++; $display("FAIL dread_latency: got %0d want 3", ob_lat); end
    checks++; if (ob_d_rv !== 1'b1 || ob_i_rv !== 1'b0 || ob_rdata !== 32'hDEADBEEF || ob_err !== 1'b0) begin errors++; $display("FAIL dread_rsp: got drv=%b irv=%b rdata=%h err=%b want 1 0 deadbeef 0", ob_d_rv, ob_i_rv, ob_rdata, ob_err); end
    step();
    checks++; if (d_rvalid_o !== 1'b0) begin errors++; $display("FAIL dread_pulse_width: got %b want 0", d_rvalid_o); end
  endtask

  task automatic test_d_write();
    bit to_i;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h200; d_wdata_i = 32'h12345678; d_be_i = 4'b0011;
    model_pick(1'b1, 1'b0, to_i);
    run_one(0, 0, 32'h0, 0);
    checks++; if ({ob_we, ob_addr, ob_wdata, ob_be} !== {1'b1, 32'h200, 32'h12345678, 4'b0011}) begin errors++; $display("FAIL dwrite_payload: got we=%b addr=%h wdata=%h be=%b want 1 200 12345678 0011", ob_we, ob_addr, ob_wdata, ob_be); end
    checks++; if (ob_d_rv !== 1'b1 || ob_i_rv !== 1'b0 || ob_lat !== 2) begin errors++; $display("FAIL dwrite_rsp: got drv=%b irv=%b lat=%0d want 1 0 2", ob_d_rv, ob_i_rv, ob_lat); end
    d_we_i = 0;
    step();
    checks++; if (d_rvalid_o !== 1'b0) begin errors++; $display("FAIL dwrite_single_pulse: got %b want 0", d_rvalid_o); end
  endtask

  task automatic test_timeout();
    bit to_i;
    i_req_i = 1; i_addr_i = 32'h40;
    model_pick(1'b0, 1'b1, to_i);
    run_one(0, -1, 32'h0, 0);
    checks++; if ({ob_d_gnt, ob_i_gnt} !== 2'b01) begin errors++; $display("FAIL tmo_gnt: got d=%b i=%b want d=0 i=1", ob_d_gnt, ob_i_gnt); end
    checks++; if ({ob_we, ob_addr, ob_wdata, ob_be} !== {1'b0, 32'h40, 32'h0, 4'hF}) begin errors++; $display("FAIL tmo_fetch_payload: got we=%b addr=%h wdata=%h be=%h want 0 40 0 f", ob_we, ob_addr, ob_wdata, ob_be); end
    checks++; if (ob_lat !== TIMEOUT_CYC + 1) begin errors++; $display("FAIL tmo_latency: got %0d want %0d", ob_lat, TIMEOUT_CYC + 1); end
    checks++; if (ob_i_rv !== 1'b1 || ob_d_rv !== 1'b0 || ob_err !== 1'b1 || ob_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rsp: got irv=%b drv=%b err=%b rdata=%h want 1 0 1 0", ob_i_rv, ob_d_rv, ob_err, ob_rdata); end
    step();
    step();
    bus_rvalid_i = 1; bus_rdata_i = 32'hCAFE0000;
    step();
    bus_rvalid_i = 0;
    for (int n = 0; n < 3; n++) begin
      checks++; if ({d_rvalid_o, i_rvalid_o} !== 2'b00 || i_rdata_o !== 32'h0) begin errors++; $display("FAIL tmo_stray_rvalid: got drv=%b irv=%b irdata=%h want 0 0 0", d_rvalid_o, i_rvalid_o, i_rdata_o); end
      step();
    end
  endtask

  task automatic test_backpressure();
    bit to_i;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'hA0; d_wdata_i = 32'h55AA55AA; d_be_i = 4'b1100;
    i_req_i = 1; i_addr_i = 32'h80;
    model_pick(1'b1, 1'b1, to_i);
    run_one(5, 0, 32'h0, 0);
    checks++; if ({ob_d_gnt, ob_i_gnt} !== {!to_i, to_i}) begin errors++; $display("FAIL bp_winner: got d=%b i=%b want d=%b i=%b", ob_d_gnt, ob_i_gnt, !to_i, to_i); end
    checks++; if (ob_stable !== 1'b1 || ob_extra_gnt !== 1'b0) begin errors++; $display("FAIL bp_hold: got stable=%b extra_gnt=%b want 1 0", ob_stable, ob_extra_gnt); end
    checks++; if ({ob_we, ob_addr, ob_wdata, ob_be} !== {1'b1, 32'hA0, 32'h55AA55AA, 4'b1100}) begin errors++; $display("FAIL bp_payload: got we=%b addr=%h wdata=%h be=%b", ob_we, ob_addr, ob_wdata, ob_be); end
    model_pick(d_req_i, i_req_i, to_i);
    run_one(0, 0, 32'h0BADF00D, 0);
    checks++; if ({ob_i_gnt, ob_i_rv, ob_rdata} !== {1'b1, 1'b1, 32'h0BADF00D}) begin errors++; $display("FAIL bp_followup_fetch: got gnt=%b rv=%b rdata=%h want 1 1 0badf00d", ob_i_gnt, ob_i_rv, ob_rdata); end
    d_we_i = 0;
  endtask

  task automatic test_contention();
    bit to_i;
    int prev_cyc;
    int since_i;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h500; d_be_i = 4'hF;
    i_req_i = 1; i_addr_i = 32'h600;
    prev_cyc = 0;
    since_i = 0;
    for (int n = 0; n < 12; n++) begin
      model_pick(d_req_i, i_req_i, to_i);
      run_one(0, 0, 32'(n), n < 10);
      checks++; if ({ob_d_gnt, ob_i_gnt} !== {!to_i, to_i}) begin errors++; $display("FAIL cont_order[%0d]: got d=%b i=%b want d=%b i=%b", n, ob_d_gnt, ob_i_gnt, !to_i, to_i); end
      if (n < 10) begin
        checks++; if (ob_i_gnt !== ((n % 5) == 4)) begin errors++; $display("FAIL cont_pattern[%0d]: got i_gnt=%b want %b", n, ob_i_gnt, (n % 5) == 4); end
      end
      since_i = ob_i_gnt ? 0 : since_i + 1;
      checks++; if (since_i > MAX_D_STREAK || ob_extra_gnt !== 1'b0) begin errors++; $display("FAIL cont_starve[%0d]: got d_run=%0d extra_gnt=%b want <=%0d 0", n, since_i, ob_extra_gnt, MAX_D_STREAK); end
      if (n > 0) begin
        checks++; if (ob_gnt_cyc - prev_cyc !== 3) begin errors++; $display("FAIL cont_throughput[%0d]: got %0d cycles want 3", n, ob_gnt_cyc - prev_cyc); end
      end
      prev_cyc = ob_gnt_cyc;
    end
  endtask

  task automatic test_random();
    bit to_i;
    int gd, rd;
    logic [31:0] data, e_addr, e_wdata;
    logic [3:0]  e_be;
    logic        e_we, e_tmo;
    for (int n = 0; n < 60; n++) begin
      if (n >= 40 && !d_req_i && !i_req_i) break;
      if (n < 40) begin
        if (!d_req_i && $urandom_range(0, 2) != 0) begin
          d_req_i = 1; d_we_i = 1'($urandom); d_addr_i = $urandom; d_wdata_i = $urandom; d_be_i = 4'($urandom);
        end
        if (!i_req_i && $urandom_range(0, 2) != 0) begin
          i_req_i = 1; i_addr_i = $urandom;
        end
        if (!d_req_i && !i_req_i) d_req_i = 1;
      end
      model_pick(d_req_i, i_req_i, to_i);
      e_we    = to_i ? 1'b0 : d_we_i;
      e_addr  = to_i ? i_addr_i : d_addr_i;
      e_wdata = to_i ? 32'h0 : d_wdata_i;
      e_be    = to_i ? 4'hF : d_be_i;
      gd   = $urandom_range(0, 3);
      rd   = $urandom_range(0, TIMEOUT_CYC + 1);
      data = $urandom;
      e_tmo = (rd > TIMEOUT_CYC - 1);
      run_one(gd, rd, data, 0);
      checks++; if ({ob_d_gnt, ob_i_gnt} !== {!to_i, to_i}) begin errors++; $display("FAIL rand_winner[%0d]: got d=%b i=%b want d=%b i=%b", n, ob_d_gnt, ob_i_gnt, !to_i, to_i); end
      checks++; if ({ob_we, ob_addr, ob_wdata, ob_be} !== {e_we, e_addr, e_wdata, e_be} || ob_stable !== 1'b1) begin errors++; $display("FAIL rand_payload[%0d]: got we=%b addr=%h wdata=%h be=%h stable=%b want %b %h %h %h 1", n, ob_we, ob_addr, ob_wdata, ob_be, ob_stable, e_we, e_addr, e_wdata, e_be); end
      checks++; if (ob_lat !== (e_tmo ? TIMEOUT_CYC + 1 : rd + 2)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, ob_lat, e_tmo ? TIMEOUT_CYC + 1 : rd + 2); end
      checks++; if ({ob_d_rv, ob_i_rv} !== {!to_i, to_i} || ob_err !== e_tmo || ob_rdata !== (e_tmo ? 32'h0 : data)) begin errors++; $display("FAIL rand_rsp[%0d]: got drv=%b irv=%b err=%b rdata=%h want %b %b %b %h", n, ob_d_rv, ob_i_rv, ob_err, ob_rdata, !to_i, to_i, e_tmo, e_tmo ? 32'h0 : data); end
      checks++; if (ob_extra_gnt !== 1'b0 || ob_rv_stale !== 1'b0) begin errors++; $display("FAIL rand_protocol[%0d]: got extra_gnt=%b stale_rv=%b want 0 0", n, ob_extra_gnt, ob_rv_stale); end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit to_i;
    step();
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h300; d_be_i = 4'hF;
    #1;
    step();
    d_req_i = 0;
    bus_gnt_i = 1;
    step();
    bus_gnt_i = 0;
    step();
    step();
    rst_n = 0;
    step();
    rst_n = 1;
    d_run = 0;
    checks++; if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} !== 70'd0) begin errors++; $display("FAIL rstwait_bus: got req=%b we=%b addr=%h wdata=%h be=%h want all 0", bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o); end
    checks++; if ({d_rvalid_o, i_rvalid_o, d_err_o, i_err_o, d_rdata_o, i_rdata_o} !== 68'd0) begin errors++; $display("FAIL rstwait_rsp: got drv=%b irv=%b derr=%b ierr=%b drdata=%h irdata=%h want all 0", d_rvalid_o, i_rvalid_o, d_err_o, i_err_o, d_rdata_o, i_rdata_o); end
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h400;
    model_pick(1'b1, 1'b0, to_i);
    run_one(0, 0, 32'hFEEDFACE, 0);
    checks++; if (ob_d_gnt !== 1'b1 || ob_addr !== 32'h400) begin errors++; $display("FAIL rstwait_regrant: got gnt=%b addr=%h want 1 400", ob_d_gnt, ob_addr); end
    checks++; if (ob_rv_stale !== 1'b0 || ob_lat !== 2 || ob_rdata !== 32'hFEEDFACE) begin errors++; $display("FAIL rstwait_rsp2: got stale=%b lat=%0d rdata=%h want 0 2 feedface", ob_rv_stale, ob_lat, ob_rdata); end
  endtask

  initial begin
    test_reset();
    test_d_read();
    test_d_write();
    test_timeout();
    test_backpressure();
    test_contention();
    test_random();
    test_reset_mid_wait();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
